// File: rtl/riscv_pkg.sv
// Shared RISC-V core types used by the execution back end.
// Only the pieces the FU completion path needs are defined here:
//   ReorderBufferTagWidth - width of a ROB tag
//   fu_complete_t         - one result leaving a functional unit
package riscv_pkg;

    localparam int unsigned ReorderBufferTagWidth = 5;
    localparam int unsigned FLEN                  = 64;

    typedef struct packed {
        logic                             valid;
        logic [ReorderBufferTagWidth-1:0] tag;
        logic [FLEN-1:0]                  value;
        logic                             exception;
        logic [4:0]                       fflags;
    } fu_complete_t;

endpackage

// File: rtl/fu_cdb_adapter.sv
// fu_cdb_adapter
// Small circular FIFO between a long-latency FU shim and the CDB arbiter.
// Each completion is buffered with a live bit; flushes clear live bits so
// squashed results drain silently instead of reaching the CDB.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_fu_complete       completion from the FU shim, pushed when .valid
//   o_cdb_req           oldest entry is buffered and live
//   o_cdb_data          oldest entry (all-zero when o_cdb_req is low)
//   i_cdb_grant         arbiter grant for o_cdb_req
//   o_full, o_empty     decoded from the registered entry count
//   o_overflow          sticky: a completion arrived while full and was dropped
//   i_flush             full flush
//   i_flush_en          partial flush: kill entries younger than i_flush_tag
//   i_flush_tag         partial flush boundary (survives)
//   i_rob_head_tag      ROB head, the origin for tag age comparison
module fu_cdb_adapter
    import riscv_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned TagW  = riscv_pkg::ReorderBufferTagWidth
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  fu_complete_t        i_fu_complete,
    output logic                o_cdb_req,
    output fu_complete_t        o_cdb_data,
    input  logic                i_cdb_grant,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_overflow,
    input  logic                i_flush,
    input  logic                i_flush_en,
    input  logic [TagW-1:0]     i_flush_tag,
    input  logic [TagW-1:0]     i_rob_head_tag
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fu_complete_t     entry_q [Depth];
    logic [Depth-1:0] live_q, live_d;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             overflow_q;

    logic             not_empty, full, head_live;
    logic             pop, push, drop;
    logic [TagW-1:0]  flush_age;

    // Distance of a tag from the ROB head; modular so it survives tag wrap.
    function automatic logic [TagW-1:0] age(input logic [TagW-1:0] t,
                                            input logic [TagW-1:0] head);
        return t - head;
    endfunction

    assign flush_age = age(i_flush_tag, i_rob_head_tag);
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CntW'(Depth));
    assign head_live = live_q[rd_ptr_q];

    // Request comes from registered state only; an arriving completion is
    // visible one cycle later.
    assign o_cdb_req = not_empty && head_live;

    // Dead heads are discarded without waiting for the arbiter.
    assign pop  = not_empty && ((o_cdb_req && i_cdb_grant) || !head_live);
    assign push = i_fu_complete.valid && (!full || pop);
    assign drop = i_fu_complete.valid && full && !pop;

    always_comb begin
        // NOTE: defaults come first so no branch leaves a signal unassigned and infers a latch.
        o_cdb_data = '0;
        if (o_cdb_req) begin
            o_cdb_data       = entry_q[rd_ptr_q];
            o_cdb_data.valid = 1'b1;
        end
    end

    // Next live vector: partial-flush kills, then the freed head slot, then
    // the arriving entry (which sees the same-cycle flush), then full flush.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < Depth; i++) begin
            if (i_flush_en && (age(TagW'(entry_q[i].tag), i_rob_head_tag) > flush_age))
                live_d[i] = 1'b0;
        end
        if (pop)
            live_d[rd_ptr_q] = 1'b0;
        if (push)
            live_d[wr_ptr_q] = !(i_flush_en &&
                                 (age(TagW'(i_fu_complete.tag), i_rob_head_tag) > flush_age));
        if (i_flush)
            live_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            live_q     <= '0;
            overflow_q <= 1'b0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            live_q <= live_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    // NOTE: payload storage has no reset; live bits and count gate every read, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (push)
            entry_q[wr_ptr_q] <= i_fu_complete;
    end

    assign o_full     = full;
    assign o_empty    = !not_empty;
    assign o_overflow = overflow_q;

endmodule
